// File: rtl/gbuff_out_writer_pkg.sv
// rtl/gbuff_out_writer_pkg.sv - shared constants, state encoding and tile helper for the GBUFF_OUT writer
//
// Purpose: common definitions imported by gbuff_out_writer and out_row_packer.
// Ports:   none (package).
// Config:  OUT_SATURATE_EN is consumed by out_row_packer; nothing here depends on it.
package gbuff_out_writer_pkg;

   localparam int ARRAY_DIM = 5;
   localparam int ACC_W     = 16;
   localparam int ELEM_W    = 8;
   localparam int ADDR_W    = 8;
   localparam int CNT_W     = 4;
   localparam int ROW_W     = ARRAY_DIM * ACC_W;
   localparam int WORD_W    = ARRAY_DIM * ELEM_W;
   localparam int COL_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Number of ARRAY_DIM-wide column tiles covering cols columns, i.e. ceil(cols/ARRAY_DIM).
   // Only meaningful for cols != 0; the zero case never enters BUSY.
   function automatic logic [CNT_W-1:0] tiles_for(input logic [CNT_W-1:0] cols);
      logic [CNT_W-1:0] dim;
      dim = CNT_W'(ARRAY_DIM);
      return ((cols - CNT_W'(1)) / dim) + CNT_W'(1);
   endfunction

endpackage

// File: rtl/gbuff_out_writer_out_row_packer.sv
// rtl/gbuff_out_writer_out_row_packer.sv - narrows one result row to bytes and masks columns past n
//
// Purpose: combinational packer; element j of res_data (element 0 in MSBs) becomes
//          byte j of word (byte 0 in [39:32]). Columns t*ARRAY_DIM+j >= n are zeroed.
// Ports:   res_data in  ROW_W  row of accumulator elements
//          t        in  CNT_W  current column tile
//          n        in  CNT_W  result column count
//          word     out WORD_W packed, masked word
// Config:  OUT_SATURATE_EN defined   -> elements above the byte range clamp to all ones
//          OUT_SATURATE_EN undefined -> elements keep their low ELEM_W bits
module out_row_packer
   import gbuff_out_writer_pkg::*;
(
   input  logic [ROW_W-1:0]  res_data,
   input  logic [CNT_W-1:0]  t,
   input  logic [CNT_W-1:0]  n,
   output logic [WORD_W-1:0] word
);

   logic [ACC_W-1:0]     acc;
   logic [ELEM_W-1:0]    byte_v;
   logic [COL_W-1:0]     col;
   logic [ARRAY_DIM-1:0] elem_over;

   always_comb begin
      word      = '0;
      acc       = '0;
      byte_v    = '0;
      col       = '0;
      elem_over = '0;
      for (int j = 0; j < ARRAY_DIM; j++) begin
         acc          = res_data[ROW_W-1-j*ACC_W -: ACC_W];
         elem_over[j] = |acc[ACC_W-1:ELEM_W];
         byte_v       = acc[ELEM_W-1:0];
`ifdef OUT_SATURATE_EN
         if (elem_over[j]) begin
            byte_v = '1;
         end
`endif
         // Masking is applied after narrowing so a clamped value never leaks into a dead column.
         col = COL_W'(t) * COL_W'(ARRAY_DIM) + COL_W'(j);
         if (col < COL_W'(n)) begin
            word[WORD_W-1-j*ELEM_W -: ELEM_W] = byte_v;
         end
      end
   end

`ifndef OUT_SATURATE_EN
   logic unused_over;
   assign unused_over = ^elem_over;
`endif

endmodule

// File: rtl/gbuff_out_writer.sv
// rtl/gbuff_out_writer.sv - writes systolic drain rows into GBUFF_OUT, tiled by column block
//
// Purpose: accepts one result row per beat (tile-major: all rows of tile 0, then tile 1, ...),
//          packs it via out_row_packer and issues a registered write to
//          GBUFF_OUT[r*tiles + t] one cycle after acceptance.
// Ports:   clk, rst (sync, active-low)
//          start, m, n            job launch (sampled in IDLE only)
//          res_valid/res_ready    row handshake, res_data row elements (element 0 in MSBs)
//          wr_en/wr_addr/wr_data  GBUFF_OUT write port
//          busy, done             job status; done pulses during the single FIN cycle
// Config:  OUT_SATURATE_EN selects saturating narrowing inside out_row_packer.
module gbuff_out_writer
   import gbuff_out_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        m,
   input  logic [3:0]        n,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ROW_W-1:0]  res_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  m_q, m_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  tiles_q, tiles_d;   // also the row stride in GBUFF_OUT
   logic [CNT_W-1:0]  r_q, r_d;
   logic [CNT_W-1:0]  t_q, t_d;
   logic [ADDR_W-1:0] row_addr_q, row_addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic [WORD_W-1:0] packed_word;
   logic              beat;

   out_row_packer u_packer (
      .res_data (res_data),
      .t        (t_q),
      .n        (n_q),
      .word     (packed_word)
   );

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      tiles_d    = tiles_q;
      r_d        = r_q;
      t_d        = t_q;
      row_addr_d = row_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      beat       = res_valid && (state_q == ST_BUSY);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               m_d        = m;
               n_d        = n;
               tiles_d    = tiles_for(n);
               r_d        = '0;
               t_d        = '0;
               row_addr_d = '0;
               state_d    = ((m == '0) || (n == '0)) ? ST_FIN : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (beat) begin
               wr_en_d   = 1'b1;
               wr_addr_d = row_addr_q;
               wr_data_d = packed_word;
               // Strided address walk: add the row stride per beat, restart at the
               // next tile's column on row wrap, so no multiplier is needed.
               if (r_q == m_q - CNT_W'(1)) begin
                  r_d        = '0;
                  t_d        = t_q + CNT_W'(1);
                  row_addr_d = ADDR_W'(t_q) + ADDR_W'(1);
                  if (t_q == tiles_q - CNT_W'(1)) begin
                     state_d = ST_FIN;
                  end
               end else begin
                  r_d        = r_q + CNT_W'(1);
                  row_addr_d = row_addr_q + ADDR_W'(tiles_q);
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         m_q        <= '0;
         n_q        <= '0;
         tiles_q    <= '0;
         r_q        <= '0;
         t_q        <= '0;
         row_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         n_q        <= n_d;
         tiles_q    <= tiles_d;
         r_q        <= r_d;
         t_q        <= t_d;
         row_addr_q <= row_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign res_ready = (state_q == ST_BUSY);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
